// File: rtl/cgia_pkg.sv
// Shared CGIA constants and types: bus address width, default line length,
// and the fetcher state encoding.
package cgia_pkg;

    localparam int CGIA_ADR_W      = 23;
    localparam int CGIA_LINE_WORDS = 40;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } fetch_state_e;

    // A one-word line still needs a 1-bit counter.
    function automatic int cntWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cgia_fetcher.sv
// CGIA video DMA fetcher: non-pipelined Wishbone master that walks the frame
// buffer one 16-bit word per clock for a fixed number of words per scan line.
module cgia_fetcher
    import cgia_pkg::*;
#(
    parameter int LINE_WORDS = CGIA_LINE_WORDS
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  den_i,
    input  logic                  hsync_i,
    input  logic                  vsync_i,
    input  logic [CGIA_ADR_W-1:0] fb_adr_i,
    output logic                  cyc_o,
    output logic [CGIA_ADR_W-1:0] adr_o
);

    localparam int CNT_W = cntWidth(LINE_WORDS);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LINE_WORDS - 1);

    fetch_state_e          state_q;
    logic                  cyc_q;
    logic [CGIA_ADR_W-1:0] adr_q;
    logic [CGIA_ADR_W-1:0] adr_d;
    logic [CNT_W-1:0]      cnt_q;
    logic                  line_done_q;

    // Natural 23-bit overflow gives the required wrap from 7FFFFF to 000000.
    assign adr_d = adr_q + CGIA_ADR_W'(1);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            cyc_q       <= 1'b0;
            adr_q       <= '0;
            cnt_q       <= '0;
            line_done_q <= 1'b0;
        end else begin
            // line_done_q blocks a second burst within one long HSYNC pulse.
            if (!hsync_i) begin
                line_done_q <= 1'b0;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (vsync_i) begin
                        adr_q <= fb_adr_i;
                    end else if (hsync_i && den_i && !line_done_q) begin
                        state_q     <= ST_FETCH;
                        cyc_q       <= 1'b1;
                        cnt_q       <= CNT_LOAD;
                        line_done_q <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (vsync_i) begin
                        state_q <= ST_IDLE;
                        cyc_q   <= 1'b0;
                        adr_q   <= fb_adr_i;
                    end else begin
                        adr_q <= adr_d;
                        if (cnt_q == '0) begin
                            state_q <= ST_IDLE;
                            cyc_q   <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cyc_q   <= 1'b0;
                end
            endcase
        end
    end

    assign cyc_o = cyc_q;
    assign adr_o = adr_q;

endmodule

// File: tb/tb_cgia_fetcher.sv
// Scoreboard bench for cgia_fetcher with a 4-word line: expected bus addresses
// are queued with each stimulus and popped by a monitor while cyc_o is high.
module tb_cgia_fetcher;

    localparam int LW = 4;

    logic        clk;
    logic        reset_i;
    logic        den_i;
    logic        hsync_i;
    logic        vsync_i;
    logic [22:0] fb_adr_i;
    logic        cyc_o;
    logic [22:0] adr_o;

    logic [22:0] expQ[$];
    int          testsRun;
    int          testsFailed;

    cgia_fetcher #(.LINE_WORDS(LW)) dut (
        .clk_i    (clk),
        .reset_i  (reset_i),
        .den_i    (den_i),
        .hsync_i  (hsync_i),
        .vsync_i  (vsync_i),
        .fb_adr_i (fb_adr_i),
        .cyc_o    (cyc_o),
        .adr_o    (adr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [23:0] actual,
                               input logic [23:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %06h, expected %06h", name, actual, expected);
        end
    endtask

    // Outputs settle by the falling edge; checks run just after it.
    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic pushBurst(input logic [22:0] base, input int n);
        for (int i = 0; i < n; i++) expQ.push_back(base + 23'(i));
    endtask

    task automatic applyStimulus(input logic h, input logic d, input logic v);
        hsync_i = h;
        den_i   = d;
        vsync_i = v;
    endtask

    // Monitor: every bus cycle seen must match the next queued address.
    always @(negedge clk) begin
        if (!reset_i && cyc_o) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_cyc", {adr_o, 1'b0}, 24'hFFFFFF);
            end else begin
                logic [22:0] e;
                e = expQ.pop_front();
                checkOutput("burst_adr", {adr_o, 1'b0}, {e, 1'b0});
            end
        end
    end

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        fb_adr_i    = '0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        reset_i = 1'b1;

        // Reset and first clock after release.
        stepCycle();
        checkOutput("reset_cyc", 24'(cyc_o), 24'h0);
        checkOutput("reset_adr", {adr_o, 1'b0}, 24'h0);
        reset_i = 1'b0;
        stepCycle();
        checkOutput("post_reset_cyc", 24'(cyc_o), 24'h0);

        // VSYNC loads the base.
        fb_adr_i = 23'h7F8000;
        applyStimulus(1'b0, 1'b0, 1'b1);
        stepCycle();
        checkOutput("vsync_load_adr", {adr_o, 1'b0}, 24'hFF0000);
        checkOutput("vsync_load_cyc", 24'(cyc_o), 24'h0);

        // VSYNC has priority, then den rising mid-pulse starts a fetch.
        applyStimulus(1'b1, 1'b0, 1'b1);
        stepCycle();
        checkOutput("vsync_prio_cyc", 24'(cyc_o), 24'h0);
        pushBurst(23'h7F8000, LW);
        applyStimulus(1'b1, 1'b1, 1'b0);
        stepCycle();
        checkOutput("fetch_start_cyc", 24'(cyc_o), 24'h1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        stepCycle();
        checkOutput("fetch_second_cyc", 24'(cyc_o), 24'h1);
        repeat (5) stepCycle();
        checkOutput("line1_drained", 24'(expQ.size()), 24'h0);
        checkOutput("line1_end_cyc", 24'(cyc_o), 24'h0);
        checkOutput("line1_end_adr", {adr_o, 1'b0}, 24'hFF0008);

        // Long HSYNC yields a single burst; a new pulse yields another.
        pushBurst(23'h7F8004, LW);
        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (10) stepCycle();
        checkOutput("long_hsync_drained", 24'(expQ.size()), 24'h0);
        checkOutput("long_hsync_cyc", 24'(cyc_o), 24'h0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        stepCycle();
        pushBurst(23'h7F8008, LW);
        applyStimulus(1'b1, 1'b1, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (6) stepCycle();
        checkOutput("line3_drained", 24'(expQ.size()), 24'h0);
        checkOutput("line3_end_adr", {adr_o, 1'b0}, 24'hFF0018);

        // VSYNC on the second fetch clock aborts and reloads the base.
        pushBurst(23'h7F800C, 2);
        applyStimulus(1'b1, 1'b1, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 1'b1, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 1'b1, 1'b1);
        stepCycle();
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("abort_cyc", 24'(cyc_o), 24'h0);
        checkOutput("abort_adr", {adr_o, 1'b0}, 24'hFF0000);
        checkOutput("abort_drained", 24'(expQ.size()), 24'h0);

        // Address wraps modulo 2^23 words.
        fb_adr_i = 23'h7FFFFF;
        applyStimulus(1'b0, 1'b1, 1'b1);
        stepCycle();
        pushBurst(23'h7FFFFF, LW);
        applyStimulus(1'b1, 1'b1, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (6) stepCycle();
        checkOutput("wrap_drained", 24'(expQ.size()), 24'h0);
        checkOutput("wrap_end_adr", {adr_o, 1'b0}, 24'h000006);

        // Reset mid-fetch drops cyc immediately.
        pushBurst(23'h000003, 1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        stepCycle();
        reset_i = 1'b1;
        #1;
        checkOutput("async_reset_cyc", 24'(cyc_o), 24'h0);
        checkOutput("async_reset_adr", {adr_o, 1'b0}, 24'h0);
        checkOutput("async_reset_drained", 24'(expQ.size()), 24'h0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        stepCycle();
        reset_i = 1'b0;
        stepCycle();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
